// File: rtl/cpu_fetch_unit.sv
// Instruction fetch unit: PC, IR and a one-entry fetch buffer in front of instruction memory.
// Define FETCH_PREFETCH_EN to prefetch at PC from EMPTY without waiting for IL.
module cpu_fetch_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  PS,
    input  logic        IL,
    input  logic [7:0]  jump_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ack,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    output logic [3:0]  opcode,
    output logic [3:0]  Rd,
    output logic [3:0]  Ra,
    output logic [3:0]  Rb,
    output logic [7:0]  PC,
    output logic        stall
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2
    } buf_state_e;

    buf_state_e  state_q, state_d;
    logic        flush_q, flush_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] buf_q, buf_d;
    logic [7:0]  addr_q, addr_d;
    logic        stall_int;
    logic        pc_change;
    logic        start_fetch;

    assign stall_int = IL && (state_q != VALID);

`ifdef FETCH_PREFETCH_EN
    assign start_fetch = 1'b1;
`else
    assign start_fetch = IL;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            flush_q <= 1'b0;
            pc_q    <= '0;
            ir_q    <= '0;
            buf_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        pc_d = pc_q;
        if (!stall_int) begin
            unique case (PS)
                2'b01:   pc_d = pc_q + 8'd1;
                // 8-bit offset sign-extended to the 8-bit PC is the offset itself
                2'b10:   pc_d = pc_q + ir_q[7:0];
                2'b11:   pc_d = jump_addr;
                default: pc_d = pc_q;
            endcase
        end
        pc_change = (pc_d != pc_q);

        state_d = state_q;
        flush_d = flush_q;
        ir_d    = ir_q;
        buf_d   = buf_q;
        addr_d  = addr_q;

        unique case (state_q)
            EMPTY: begin
                // Latch the post-edge PC so a redirect in this same cycle is fetched directly
                if (start_fetch) begin
                    state_d = WAIT;
                    addr_d  = pc_d;
                    flush_d = 1'b0;
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    if (flush_q || pc_change) begin
                        state_d = EMPTY;
                    end else begin
                        state_d = VALID;
                        buf_d   = imem_rdata;
                    end
                    flush_d = 1'b0;
                end else if (pc_change) begin
                    flush_d = 1'b1;
                end
            end
            VALID: begin
                if (IL) begin
                    ir_d = buf_q;
                end
                if (IL || pc_change) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        imem_req  = (state_q == WAIT);
        imem_addr = addr_q;
        stall     = stall_int && !reset;
        PC        = pc_q;
        opcode    = ir_q[15:12];
        Rd        = ir_q[11:8];
        Ra        = ir_q[7:4];
        Rb        = ir_q[3:0];
    end

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Scoreboard bench for cpu_fetch_unit: a behavioural model predicts per-cycle outputs,
// a monitor compares them against the DUT at the falling edge.
module tb_cpu_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  PS;
    logic        IL;
    logic [7:0]  jump_addr;
    logic [15:0] imem_rdata;
    logic        imem_ack;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [3:0]  opcode, Rd, Ra, Rb;
    logic [7:0]  PC;
    logic        stall;

    always #5 clk = ~clk;

    cpu_fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .PS         (PS),
        .IL         (IL),
        .jump_addr  (jump_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .opcode     (opcode),
        .Rd         (Rd),
        .Ra         (Ra),
        .Rb         (Rb),
        .PC         (PC),
        .stall      (stall)
    );

`ifdef FETCH_PREFETCH_EN
    localparam bit PREFETCH = 1'b1;
`else
    localparam bit PREFETCH = 1'b0;
`endif

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] ir;
        logic        req;
        logic [7:0]  addr;
        logic        stall;
    } exp_t;

    exp_t exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [15:0] mem [256];

    // Model: PC, IR, a held word (if any), an outstanding fetch (if any) and whether it went stale
    int m_pc, m_ir, m_word, m_addr;
    bit m_have, m_pend, m_stale, m_ok = 1'b0;

    int lat_cfg   = 1;
    int req_age   = 0;
    bit force_ack = 1'b0;

    function automatic void check(input string name, input logic [15:0] act, input logic [15:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("pc",        {8'h00, PC},            {8'h00, e.pc});
            check("ir",        {opcode, Rd, Ra, Rb},   e.ir);
            check("imem_req",  {15'h0, imem_req},      {15'h0, e.req});
            check("imem_addr", {8'h00, imem_addr},     {8'h00, e.addr});
            check("stall",     {15'h0, stall},         {15'h0, e.stall});
        end
    end

    task automatic model_update(input bit rst, input bit il, input logic [1:0] ps,
                                input logic [7:0] ja, input bit ack);
        int npc, off;
        bit stl, chg, had, pend;
        if (rst) begin
            m_pc = 0; m_ir = 0; m_have = 0; m_pend = 0; m_stale = 0; m_addr = 0; m_ok = 1;
            return;
        end
        stl = il && !m_have;
        npc = m_pc;
        if (!stl) begin
            case (ps)
                2'b01: npc = (m_pc + 1) % 256;
                2'b10: begin
                    off = m_ir % 256;
                    if (off >= 128) off = off - 256;
                    npc = (m_pc + off + 256) % 256;
                end
                2'b11: npc = int'(ja);
                default: npc = m_pc;
            endcase
        end
        chg  = (npc != m_pc);
        had  = m_have;
        pend = m_pend;
        if (had && il) m_ir = m_word;
        if (had && (il || chg)) m_have = 0;
        if (pend) begin
            if (ack) begin
                m_pend = 0;
                if (!m_stale && !chg) begin
                    m_have = 1;
                    m_word = int'(mem[m_addr]);
                end
                m_stale = 0;
            end else if (chg) begin
                m_stale = 1;
            end
        end else if (!had && (PREFETCH || il)) begin
            m_pend  = 1;
            m_addr  = npc;
            m_stale = 0;
        end
        m_pc = npc;
    endtask

    task automatic step(input bit rst, input bit il, input logic [1:0] ps, input logic [7:0] ja);
        exp_t e;
        reset     = rst;
        IL        = il;
        PS        = ps;
        jump_addr = ja;
        if (force_ack) begin
            imem_ack   = 1'b1;
            imem_rdata = 16'($urandom);
            force_ack  = 1'b0;
        end else if (!rst && imem_req === 1'b1) begin
            req_age++;
            if (req_age >= lat_cfg) begin
                imem_ack   = 1'b1;
                imem_rdata = mem[imem_addr];
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 16'($urandom);
            end
        end else begin
            req_age    = 0;
            imem_ack   = 1'b0;
            imem_rdata = 16'($urandom);
        end
        if (m_ok) begin
            e.pc    = 8'(m_pc);
            e.ir    = 16'(m_ir);
            e.req   = m_pend;
            e.addr  = 8'(m_addr);
            e.stall = il && !m_have && !rst;
            exp_q.push_back(e);
        end
        @(posedge clk);
        model_update(rst, il, ps, ja, imem_ack);
        #1;
    endtask

    initial begin
        reset = 1'b1; IL = 1'b0; PS = 2'b00; jump_addr = '0; imem_ack = 1'b0; imem_rdata = '0;
        foreach (mem[i]) mem[i] = 16'($urandom);
        mem[8'h00] = 16'h1234;
        mem[8'h02] = 16'h12FC;
        mem[8'h05] = 16'hDEAD;
        mem[8'h10] = 16'hA0FE;
        @(posedge clk);
        #1;
        step(1, 0, 2'b00, 8'h00);
        step(1, 0, 2'b00, 8'h00);

        // first fetch with single-cycle ack, then consume with increment
        lat_cfg = 1;
        repeat (3) step(0, 1, 2'b01, 8'h00);
        step(0, 0, 2'b00, 8'h00);

        // slow memory: stall held while waiting
        lat_cfg = 4;
        repeat (7) step(0, 1, 2'b00, 8'h00);

        // jump to 0x10, load A0FE, branch back by 2, then jump to 0x80 and fetch there
        lat_cfg = 1;
        step(0, 0, 2'b11, 8'h10);
        repeat (8) step(0, 1, 2'b00, 8'h00);
        step(0, 0, 2'b10, 8'h00);
        step(0, 0, 2'b11, 8'h80);
        repeat (3) step(0, 1, 2'b00, 8'h00);

        // 0x02 + 0xFC wraps to 0xFE
        step(0, 0, 2'b11, 8'h02);
        repeat (8) step(0, 1, 2'b00, 8'h00);
        step(0, 0, 2'b10, 8'h00);

        // redirect while a fetch of 0x05 is outstanding
        step(0, 0, 2'b11, 8'h05);
        lat_cfg = 3;
        step(0, 1, 2'b00, 8'h00);
        step(0, 0, 2'b11, 8'h40);
        repeat (8) step(0, 1, 2'b00, 8'h00);

        // PC wrap on increment
        step(0, 0, 2'b11, 8'hFF);
        step(0, 0, 2'b01, 8'h00);
        step(0, 0, 2'b00, 8'h00);

        // reset in the middle of a fetch, with a late ack right after
        lat_cfg = 5;
        step(0, 1, 2'b00, 8'h00);
        step(0, 1, 2'b00, 8'h00);
        step(1, 1, 2'b00, 8'h00);
        force_ack = 1'b1;
        step(0, 0, 2'b00, 8'h00);
        repeat (4) step(0, 0, 2'b00, 8'h00);

        for (int i = 0; i < 3000; i++) begin
            lat_cfg = $urandom_range(1, 4);
            step(($urandom_range(0, 199) == 0), bit'($urandom_range(0, 1)),
                 2'($urandom), 8'($urandom));
        end
        step(0, 0, 2'b00, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_fetch_unit.md
CPU_FETCH_UNIT -- requirements
Module: cpu_fetch_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port PS, input, 2 bits: PC select from control logic (00 hold, 01 increment, 10 branch relative, 11 jump).
REQ-004 SHALL have port IL, input, 1 bit: instruction load request from control logic.
REQ-005 SHALL have port jump_addr, input, 8 bits: absolute target used when PS=11.
REQ-006 SHALL have port imem_rdata, input, 16 bits: instruction word from instruction memory.
REQ-007 SHALL have port imem_ack, input, 1 bit: imem_rdata valid this cycle; latency from request is 1 or more cycles.
REQ-008 SHALL have port imem_req, output, 1 bit: fetch request, level-held until ack.
REQ-009 SHALL have port imem_addr, output, 8 bits: fetch address, stable while imem_req=1.
REQ-010 SHALL have ports opcode, Rd, Ra and Rb, outputs, 4 bits each: IR[15:12], IR[11:8], IR[7:4] and IR[3:0] to control logic and datapath.
REQ-011 SHALL have port PC, output, 8 bits: current program counter.
REQ-012 SHALL have port stall, output, 1 bit, combinational: IL=1 and buffer state not VALID.

Function
REQ-013 SHALL hold a 16-bit IR, an 8-bit PC and a one-entry fetch buffer whose state is one of EMPTY, WAIT or VALID.
REQ-014 EMPTY -> WAIT SHALL occur on the start condition defined in Configuration; entering WAIT latches imem_addr=PC.
REQ-015 In WAIT the block SHALL drive imem_req=1; on imem_ack it SHALL capture imem_rdata into the buffer and go to VALID, or go to EMPTY with data discarded if the flush flag is set.
REQ-016 In EMPTY and VALID the block SHALL drive imem_req=0.
REQ-017 IL=1 in VALID SHALL load IR from the buffer at that edge and move the state to EMPTY.
REQ-018 IL=1 while stall=1 SHALL leave IR and PC unchanged, and PS SHALL be ignored that cycle.
REQ-019 When stall=0, PS SHALL update PC at the edge:
  - 01: PC+1.
  - 10: PC + sign-extended {Ra,Rb}.
  - 11: jump_addr.
REQ-020 PC arithmetic SHALL be modulo 256; 0xFF+1 gives 0x00, and 0x02 + 0xFC gives 0xFE.
REQ-021 A PC change SHALL invalidate the buffer:
  - VALID: go to EMPTY.
  - WAIT: set the flush flag; the outstanding request completes and its data is dropped.
  - Exception: IL=1 with PS=01 in VALID consumes first, then increments, with no flush.
REQ-022 imem_addr SHALL NOT change during WAIT, even when PC changes.

Reset
REQ-023 While reset=1 at a clock edge the block SHALL set PC=0x00, IR=0x0000, buffer state EMPTY and flush flag clear.
REQ-024 While reset=1 at a clock edge the block SHALL set imem_req=0, imem_addr=0x00 and stall=0, with IL forced ignored.
REQ-025 Reset during WAIT SHALL abandon the request; a late imem_ack in the cycle after reset SHALL be ignored.

Configuration
REQ-026 With FETCH_PREFETCH_EN defined, EMPTY SHALL go to WAIT on the next edge unconditionally, prefetching PC without waiting for IL.
REQ-027 Without FETCH_PREFETCH_EN, EMPTY SHALL go to WAIT only at an edge where IL=1; the minimum IL-to-IR-load latency is then 2 cycles with a 1-cycle ack.
REQ-028 The macro SHALL affect only the EMPTY->WAIT condition; all other behaviour SHALL be identical with and without it.

Verification
REQ-029 Reset, then IL=1 with PS=01 and imem_ack one cycle after imem_req, rdata=0x1234 -> opcode=1, Rd=2, Ra=3, Rb=4, PC=0x01.
REQ-030 imem_ack delayed 4 cycles with IL held -> stall=1 for exactly those cycles, PC held at 0x00, IR loads when ack arrives.
REQ-031 PC=0x10 with IR=0xA0FE and PS=10 -> PC=0x0E; PS=11 with jump_addr=0x80 -> PC=0x80, imem_addr=0x80 on the next request.
REQ-032 PS=11 issued during WAIT for address 0x05 -> ack data discarded, next request is to the new PC, IR is not loaded with the stale word.
REQ-033 PC=0xFF with PS=01 -> PC=0x00; reset asserted mid-WAIT -> imem_req=0 and PC=0x00 next cycle.
REQ-034 With FETCH_PREFETCH_EN defined -> imem_req rises the cycle after reset deasserts with IL=0; without the macro -> imem_req stays 0 until IL=1.
